stopwatch_ctrl: RTL

Control FSM for the stopwatch. It takes the three debounced button levels from the per-button debounce stages and turns them into press events. It then sequences the time-count datapath through idle, running, paused and lap-hold modes, driving its count enable, synchronous clear and display-freeze controls. It sits between the debounce stages and the counter/display datapath.

---
 rtl/stopwatch_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: turns debounced button levels into press events and
// sequences the time counter through idle, running, paused and lap-hold modes.
module stopwatch_ctrl #(
   parameter int CLK_FREQ      = 25_000_000,
   parameter int LONG_PRESS_MS = 1000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_start,
   input  logic       btn_lap,
   input  logic       btn_clear,
   output logic       run,
   output logic       clear,
   output logic       lap_freeze,
   output logic [1:0] state
);

   localparam int LONG_CYCLES = (CLK_FREQ / 1000) * LONG_PRESS_MS;
   localparam int CW          = $clog2(LONG_CYCLES + 1);

   localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_CYCLES);
   localparam logic [CW-1:0] LONG_FIRE = CW'(LONG_CYCLES - 1);

   localparam logic [1:0] S_IDLE    = 2'b00;
   localparam logic [1:0] S_RUNNING = 2'b01;
   localparam logic [1:0] S_PAUSED  = 2'b10;
   localparam logic [1:0] S_LAP     = 2'b11;

   logic          r_prev_start;
   logic          r_prev_lap;
   logic          r_prev_clear;
   logic [CW-1:0] r_long_cnt;
   logic [1:0]    r_state;
   logic          r_run;
   logic          r_clear;
   logic          r_lap_freeze;

   logic          w_ev_start;
   logic          w_ev_lap;
   logic          w_ev_clear;
   logic          w_ev_long;
   logic [1:0]    w_next_state;
   logic          w_clear_nxt;
   logic [CW-1:0] w_long_cnt_nxt;

   assign w_ev_start = btn_start & ~r_prev_start;
   assign w_ev_lap   = btn_lap   & ~r_prev_lap;
   assign w_ev_clear = btn_clear & ~r_prev_clear;

   // Gated on PAUSED so a count left over from the exit cycle can never fire.
   assign w_ev_long = (r_state == S_PAUSED) && btn_lap && (r_long_cnt == LONG_FIRE);

   always_comb begin
      w_long_cnt_nxt = '0;
      if (r_state == S_PAUSED && btn_lap) begin
         if (r_long_cnt == LONG_MAX)
            w_long_cnt_nxt = r_long_cnt;
         else
            w_long_cnt_nxt = r_long_cnt + 1'b1;
      end
   end

   // Events are examined in priority order clear > start > lap/long; the
   // first one applicable to the current state wins, the rest are dropped.
   always_comb begin
      w_next_state = r_state;
      w_clear_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_ev_clear)
               w_clear_nxt = 1'b1;
            else if (w_ev_start)
               w_next_state = S_RUNNING;
         end
         S_RUNNING: begin
            if (w_ev_start)
               w_next_state = S_PAUSED;
            else if (w_ev_lap)
               w_next_state = S_LAP;
         end
         S_LAP: begin
            if (w_ev_start)
               w_next_state = S_PAUSED;
            else if (w_ev_lap)
               w_next_state = S_RUNNING;
         end
         S_PAUSED: begin
            if (w_ev_clear) begin
               w_next_state = S_IDLE;
               w_clear_nxt  = 1'b1;
            end else if (w_ev_start) begin
               w_next_state = S_RUNNING;
            end else if (w_ev_long) begin
               w_next_state = S_IDLE;
               w_clear_nxt  = 1'b1;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // prev resets high so a button held through reset release is not an event.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prev_start <= 1'b1;
         r_prev_lap   <= 1'b1;
         r_prev_clear <= 1'b1;
         r_long_cnt   <= '0;
         r_state      <= S_IDLE;
         r_run        <= 1'b0;
         r_clear      <= 1'b0;
         r_lap_freeze <= 1'b0;
      end else begin
         r_prev_start <= btn_start;
         r_prev_lap   <= btn_lap;
         r_prev_clear <= btn_clear;
         r_long_cnt   <= w_long_cnt_nxt;
         r_state      <= w_next_state;
         r_run        <= (w_next_state == S_RUNNING) || (w_next_state == S_LAP);
         r_clear      <= w_clear_nxt;
         r_lap_freeze <= (w_next_state == S_LAP);
      end
   end

   assign run        = r_run;
   assign clear      = r_clear;
   assign lap_freeze = r_lap_freeze;
   assign state      = r_state;

endmodule
